// File: rtl/fmul_core.sv
// Two-stage pipelined binary32 multiplier: round to nearest even, subnormals flushed to zero.
// Stage 1 classifies operands and forms the exponent sum and mantissa product; stage 2 rounds and packs y.
module fmul_core (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic [31:0] y
);

    // An operand with a zero exponent is a signed zero, whatever its fraction holds.
    function automatic logic is_zero(input logic [31:0] v);
        return (v[30:23] == 8'd0);
    endfunction

    function automatic logic is_inf(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] == 23'd0);
    endfunction

    function automatic logic is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

    logic               sign_s;
    logic               nan_s;
    logic               inf_s;
    logic               zero_s;
    logic signed [9:0]  exp_sum_s;
    logic [47:0]        prod_s;

    logic               sign_r;
    logic               nan_r;
    logic               inf_r;
    logic               zero_r;
    logic signed [9:0]  exp_r;
    logic [47:0]        prod_r;
    logic [31:0]        y_r;

    logic [23:0]        sig_s;
    logic               guard_s;
    logic               sticky_s;
    logic               rnd_s;
    logic [24:0]        sum_s;
    logic signed [9:0]  exp_n_s;
    logic signed [9:0]  exp_fin_s;
    logic [22:0]        frac_s;
    logic [31:0]        y_next_s;

    // Stage-1 combinational: classification, biased exponent sum and full mantissa product.
    always_comb begin
        sign_s    = x1[31] ^ x2[31];
        nan_s     = is_nan(x1) || is_nan(x2) ||
                    (is_inf(x1) && is_zero(x2)) || (is_zero(x1) && is_inf(x2));
        inf_s     = (is_inf(x1) || is_inf(x2)) && !nan_s;
        zero_s    = (is_zero(x1) || is_zero(x2)) && !nan_s && !inf_s;
        exp_sum_s = $signed({2'b00, x1[30:23]}) + $signed({2'b00, x2[30:23]}) - 10'sd127;
        prod_s    = {24'd0, 1'b1, x1[22:0]} * {24'd0, 1'b1, x2[22:0]};
    end

    // Stage-1 pipeline registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sign_r <= 1'b0;
            nan_r  <= 1'b0;
            inf_r  <= 1'b0;
            zero_r <= 1'b0;
            exp_r  <= 10'sd0;
            prod_r <= 48'd0;
        end else begin
            sign_r <= sign_s;
            nan_r  <= nan_s;
            inf_r  <= inf_s;
            zero_r <= zero_s;
            exp_r  <= exp_sum_s;
            prod_r <= prod_s;
        end
    end

    // Stage-2 combinational: normalise, round to nearest even, then range-check and pack.
    always_comb begin
        if (prod_r[47]) begin
            sig_s    = prod_r[47:24];
            guard_s  = prod_r[23];
            sticky_s = |prod_r[22:0];
            exp_n_s  = exp_r + 10'sd1;
        end else begin
            sig_s    = prod_r[46:23];
            guard_s  = prod_r[22];
            sticky_s = |prod_r[21:0];
            exp_n_s  = exp_r;
        end

        rnd_s = guard_s & (sticky_s | sig_s[0]);
        sum_s = {1'b0, sig_s} + {24'd0, rnd_s};

        // A carry out of the rounded significand means it reached 2.0, i.e. 1.0 with exponent+1.
        if (sum_s[24]) begin
            frac_s    = 23'd0;
            exp_fin_s = exp_n_s + 10'sd1;
        end else begin
            frac_s    = sum_s[22:0];
            exp_fin_s = exp_n_s;
        end

        if (nan_r) begin
            y_next_s = 32'h7FC0_0000;
        end else if (inf_r) begin
            y_next_s = {sign_r, 8'hFF, 23'd0};
        end else if (zero_r) begin
            y_next_s = {sign_r, 31'd0};
        end else if (exp_fin_s >= 10'sd255) begin
            y_next_s = {sign_r, 8'hFF, 23'd0};
        end else if (exp_fin_s <= 10'sd0) begin
            y_next_s = {sign_r, 31'd0};
        end else begin
            y_next_s = {sign_r, exp_fin_s[7:0], frac_s};
        end
    end

    // Stage-2 output register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            y_r <= 32'd0;
        end else begin
            y_r <= y_next_s;
        end
    end

    assign y = y_r;

endmodule

// File: tb/tb_fmul_core.sv
// Self-checking bench for fmul_core: directed vectors, mid-stream reset and a random stream
// compared bit-exact against an integer round-to-nearest-even / flush-to-zero product model.
module tb_fmul_core;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] x1;
    logic [31:0] x2;
    logic [31:0] y;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    bit          inflight_v = 1'b0;
    logic [31:0] inflight_e = 32'd0;

    fmul_core dut (
        .clk  (clk),
        .rstn (rstn),
        .x1   (x1),
        .x2   (x2),
        .y    (y)
    );

    always #5 clk = ~clk;

    // Exact integer product, then rounding decided by comparing the discarded remainder with one half ulp.
    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        logic              s;
        int                ea;
        int                eb;
        int                e;
        int                sh;
        bit                a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        longint unsigned   ma, mb, p, q, rem, half;
        s      = a[31] ^ b[31];
        ea     = int'(a[30:23]);
        eb     = int'(b[30:23]);
        a_nan  = (ea == 255) && (a[22:0] != 23'd0);
        b_nan  = (eb == 255) && (b[22:0] != 23'd0);
        a_inf  = (ea == 255) && (a[22:0] == 23'd0);
        b_inf  = (eb == 255) && (b[22:0] == 23'd0);
        a_zero = (ea == 0);
        b_zero = (eb == 0);
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) return 32'h7FC0_0000;
        if (a_inf || b_inf) return {s, 8'hFF, 23'd0};
        if (a_zero || b_zero) return {s, 31'd0};
        ma   = 64'h80_0000 + 64'(a[22:0]);
        mb   = 64'h80_0000 + 64'(b[22:0]);
        p    = ma * mb;
        sh   = (p >= (64'd1 << 47)) ? 24 : 23;
        e    = ea + eb - 127 + (sh - 23);
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 64'd1 << (sh - 1);
        if ((rem > half) || ((rem == half) && (q % 64'd2 == 64'd1))) q = q + 64'd1;
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e = e + 1;
        end
        if (e >= 255) return {s, 8'hFF, 23'd0};
        if (e <= 0) return {s, 31'd0};
        return {s, 8'(e), q[22:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        x1 = a;
        x2 = b;
        exp_q.push_back(ref_mul(a, b));
    endtask

    // Compare process: just after every rising edge, y must hold the product of the pair sampled one edge earlier.
    always begin
        @(posedge clk);
        #1;
        if (!rstn) begin
            check("reset_hold", y, 32'd0);
            exp_q.delete();
            inflight_v = 1'b0;
        end else begin
            if (inflight_v) check("pipe", y, inflight_e);
            if (exp_q.size() > 0) begin
                inflight_e = exp_q.pop_front();
                inflight_v = 1'b1;
            end else begin
                inflight_v = 1'b0;
            end
        end
    end

    localparam int NDIR = 15;
    logic [31:0] dir_a [NDIR] = '{
        32'h4040_0000, 32'h0000_0000, 32'h437F_0000, 32'h4048_F5C3, 32'h3F80_0000,
        32'h4020_0000, 32'h3F80_0001, 32'h3FFF_FFFF, 32'h7F80_0000, 32'h7F80_0000,
        32'h7FC0_0000, 32'h8000_0000, 32'h7F00_0000, 32'h0080_0000, 32'h0000_0001};
    logic [31:0] dir_b [NDIR] = '{
        32'h4040_0000, 32'h0000_0000, 32'hC37F_0000, 32'h4000_0000, 32'h3F8C_CCCD,
        32'h4000_0000, 32'h3F80_0001, 32'h3FFF_FFFF, 32'hC000_0000, 32'h0000_0000,
        32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 32'h7F00_0000};
    logic [31:0] dir_y [NDIR] = '{
        32'h4110_0000, 32'h0000_0000, 32'hC77E_0100, 32'h40C8_F5C3, 32'h3F8C_CCCD,
        32'h40A0_0000, 32'h3F80_0002, 32'h407F_FFFE, 32'hFF80_0000, 32'h7FC0_0000,
        32'h7FC0_0000, 32'h8000_0000, 32'h7F80_0000, 32'h0000_0000, 32'h0000_0000};

    function automatic logic [31:0] rand_normal(input bit near_one);
        logic [7:0] e;
        if (near_one) e = 8'($urandom_range(100, 154));
        else          e = 8'($urandom_range(1, 254));
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    initial begin
        rstn = 1'b0;
        x1   = 32'd0;
        x2   = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", y, 32'd0);

        // Pin the model to hand-computed results.
        for (int i = 0; i < NDIR; i++) begin
            check($sformatf("model_dir%0d", i), ref_mul(dir_a[i], dir_b[i]), dir_y[i]);
        end

        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < NDIR; i++) drive(dir_a[i], dir_b[i]);

        for (int i = 0; i < 3000; i++) drive(rand_normal(1'b1), rand_normal(1'b1));

        // Reset asserted between edges while results are in flight.
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        check("reset_async", y, 32'd0);
        repeat (2) @(negedge clk);
        x1   = 32'h4040_0000;
        x2   = 32'h4040_0000;
        rstn = 1'b1;
        exp_q.push_back(32'h4110_0000);
        @(posedge clk);
        #1;
        check("reset_first_edge", y, 32'd0);

        for (int i = 0; i < 4000; i++) drive(rand_normal(1'b1), rand_normal(1'b1));
        for (int i = 0; i < 4000; i++) drive(rand_normal(1'b0), rand_normal(1'b0));
        for (int i = 0; i < NDIR; i++) drive(dir_a[i], dir_b[i]);

        repeat (4) @(negedge clk);
        if (exp_q.size() != 0 || inflight_v) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d results never compared", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
